// File: rtl/vga_trace_renderer_pkg.sv
// vga_trace_renderer_pkg: screen geometry constants and write-FSM state type
package vga_trace_renderer_pkg;
  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] VBI_LINE  = 10'd480;
  localparam logic [9:0] GRID_STEP = 10'd80;
  localparam logic [9:0] AXIS_LINE = 10'd240;
  typedef enum logic {FILL, FULL} wr_state_t;
endpackage

// File: rtl/vga_trace_renderer_sample_ram.sv
// trace_sample_ram: 2048 x SAMPLE_W simple dual-port RAM, one write port, one sync-read port
module trace_sample_ram #(
  parameter int SAMPLE_W = 9
) (
  input  logic                pixel_clock,
  input  logic                we,
  input  logic [10:0]         waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [10:0]         raddr,
  output logic [SAMPLE_W-1:0] rdata
);
  logic [SAMPLE_W-1:0] mem [2048];
  always_ff @(posedge pixel_clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_trace_renderer.sv
// vga_trace_renderer: draws a ping-pong buffered sample stream as a one-pixel trace; GRID_OVERLAY_EN adds a blue grid
module vga_trace_renderer
  import vga_trace_renderer_pkg::*;
#(
  parameter int         COLOR_W   = 1,
  parameter int         SAMPLE_W  = 9,
  parameter logic [2:0] TRACE_RGB = 3'b010
) (
  input  logic                pixel_clock,
  input  logic                reset,
  input  logic [9:0]          pixel_count,
  input  logic [9:0]          line_count,
  input  logic                blank_in,
  input  logic                h_synch_in,
  input  logic                v_synch_in,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [COLOR_W-1:0]  red,
  output logic [COLOR_W-1:0]  green,
  output logic [COLOR_W-1:0]  blue,
  output logic                h_synch,
  output logic                v_synch,
  output logic                blank,
  output logic                swap_pulse
);
  wr_state_t state, state_nx;
  logic [9:0] wr_addr;
  logic wr_bank, rd_bank, disp_ok;
  logic full, accept, swap_evt, last_col;
  logic [SAMPLE_W-1:0] sample_d1;
  logic [9:0] line_d1;
  logic active_d1, blank_d1, hs_d1, vs_d1, hit, grid;
  logic [2:0] rgb_nx;
  assign full         = state == FULL;
  assign sample_ready = !full;
  assign accept       = sample_valid && sample_ready;
  assign last_col     = wr_addr == H_ACTIVE - 10'd1;
  assign swap_evt     = pixel_count == 10'd0 && line_count == VBI_LINE && full;
  always_comb begin
    state_nx = state;
    state_nx = state == FILL ? ((accept && last_col) ? FULL : FILL) : (swap_evt ? FILL : FULL);
  end
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state      <= FILL;
      wr_addr    <= '0;
      wr_bank    <= 1'b1;
      rd_bank    <= 1'b0;
      disp_ok    <= 1'b0;
      swap_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      swap_pulse <= swap_evt;
      if (swap_evt) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
        wr_addr <= '0;
        disp_ok <= 1'b1;
      end else if (accept && !last_col) begin
        wr_addr <= wr_addr + 10'd1;
      end
    end
  end
  trace_sample_ram #(.SAMPLE_W(SAMPLE_W)) u_ram (
    .pixel_clock(pixel_clock),
    .we         (accept),
    .waddr      ({wr_bank, wr_addr}),
    .wdata      (sample_data),
    .raddr      ({rd_bank, pixel_count}),
    .rdata      (sample_d1)
  );
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      line_d1   <= '0;
      active_d1 <= 1'b0;
      blank_d1  <= 1'b0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
    end else begin
      line_d1   <= line_count;
      active_d1 <= pixel_count < H_ACTIVE && line_count < V_ACTIVE;
      blank_d1  <= blank_in;
      hs_d1     <= h_synch_in;
      vs_d1     <= v_synch_in;
    end
  end
  assign hit = disp_ok && active_d1 && sample_d1 == line_d1[SAMPLE_W-1:0] && line_d1 < V_ACTIVE;
`ifdef GRID_OVERLAY_EN
  logic [9:0] col_d1;
  always_ff @(posedge pixel_clock) col_d1 <= reset ? '0 : pixel_count;
  assign grid = active_d1 && (line_d1 == AXIS_LINE || col_d1 % GRID_STEP == 10'd0);
`else
  assign grid = 1'b0;
`endif
  always_comb begin
    rgb_nx = '0;
    rgb_nx = blank_d1 ? 3'b000 : hit ? TRACE_RGB : grid ? 3'b001 : 3'b000;
  end
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      h_synch <= 1'b0;
      v_synch <= 1'b0;
      blank   <= 1'b0;
    end else begin
      red     <= {COLOR_W{rgb_nx[2]}};
      green   <= {COLOR_W{rgb_nx[1]}};
      blue    <= {COLOR_W{rgb_nx[0]}};
      h_synch <= hs_d1;
      v_synch <= vs_d1;
      blank   <= blank_d1;
    end
  end
endmodule

// File: tb/tb_vga_trace_renderer.sv
// tb_vga_trace_renderer: directed checks of fill/swap, trace drawing, sync delay and reset; honours GRID_OVERLAY_EN
module tb_vga_trace_renderer;
  logic pixel_clock = 1'b0;
  logic reset;
  logic [9:0] pixel_count, line_count;
  logic blank_in, h_synch_in, v_synch_in;
  logic [8:0] sample_data;
  logic sample_valid, sample_ready;
  logic [0:0] red, green, blue;
  logic h_synch, v_synch, blank, swap_pulse;
  int total = 0;
  int bad = 0;
`ifdef GRID_OVERLAY_EN
  localparam logic [2:0] GRID_C = 3'b001;
`else
  localparam logic [2:0] GRID_C = 3'b000;
`endif
  vga_trace_renderer dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .pixel_count (pixel_count),
    .line_count  (line_count),
    .blank_in    (blank_in),
    .h_synch_in  (h_synch_in),
    .v_synch_in  (v_synch_in),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .h_synch     (h_synch),
    .v_synch     (v_synch),
    .blank       (blank),
    .swap_pulse  (swap_pulse)
  );
  always #5 pixel_clock = ~pixel_clock;
  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic tick;
    @(posedge pixel_clock);
    #1;
  endtask
  task automatic at(input logic [9:0] c, input logic [9:0] l);
    pixel_count = c;
    line_count  = l;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic pix(input logic [9:0] c, input logic [9:0] l, input logic [2:0] exp, input string tag);
    at(c, l);
    tick;
    tick;
    chk(tag, {29'd0, red, green, blue}, {29'd0, exp});
  endtask
  task automatic fill(input int n, input bit ramp, input logic [8:0] base, input int sc, input logic [8:0] sv);
    at(10'd700, 10'd10);
    sample_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      sample_data = ramp ? 9'(i % 480) : (i == sc ? sv : base);
      tick;
    end
    sample_valid = 1'b0;
  endtask
  task automatic do_swap(input logic exp, input string tag);
    at(10'd0, 10'd480);
    tick;
    chk(tag, {31'd0, swap_pulse}, {31'd0, exp});
    at(10'd1, 10'd480);
    tick;
  endtask
  initial begin
    reset = 1'b1;
    blank_in = 1'b0;
    h_synch_in = 1'b0;
    v_synch_in = 1'b0;
    sample_data = '0;
    sample_valid = 1'b0;
    at(10'd700, 10'd10);
    tick;
    tick;
    chk("rst_rgb", {29'd0, red, green, blue}, 32'd0);
    chk("rst_sync", {29'd0, h_synch, v_synch, blank}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd1);
    chk("rst_swap", {31'd0, swap_pulse}, 32'd0);
    reset = 1'b0;
    do_swap(1'b0, "noswap_empty");
    pix(10'd5, 10'd0, 3'b000, "empty_px");
    pix(10'd80, 10'd17, GRID_C, "empty_grid_col");
    pix(10'd5, 10'd240, GRID_C, "empty_grid_axis");
    at(10'd700, 10'd500);
    h_synch_in = 1'b1; v_synch_in = 1'b0; blank_in = 1'b1;
    tick;
    chk("sync_lat1", {29'd0, h_synch, v_synch, blank}, 32'd0);
    h_synch_in = 1'b0; v_synch_in = 1'b1; blank_in = 1'b0;
    tick;
    chk("sync_lat2a", {29'd0, h_synch, v_synch, blank}, 32'b101);
    tick;
    chk("sync_lat2b", {29'd0, h_synch, v_synch, blank}, 32'b010);
    v_synch_in = 1'b0;
    tick;
    tick;
    fill(639, 1'b0, 9'd100, -1, 9'd0);
    chk("ready_639", {31'd0, sample_ready}, 32'd1);
    fill(1, 1'b0, 9'd100, -1, 9'd0);
    chk("ready_640", {31'd0, sample_ready}, 32'd0);
    at(10'd0, 10'd480);
    tick;
    chk("swap1_pulse", {31'd0, swap_pulse}, 32'd1);
    chk("swap1_ready", {31'd0, sample_ready}, 32'd1);
    at(10'd1, 10'd480);
    tick;
    chk("swap1_once", {31'd0, swap_pulse}, 32'd0);
    pix(10'd5, 10'd100, 3'b010, "row100_c5");
    pix(10'd0, 10'd100, 3'b010, "row100_c0");
    pix(10'd639, 10'd100, 3'b010, "row100_c639");
    pix(10'd5, 10'd99, 3'b000, "row99_dark");
    pix(10'd700, 10'd100, 3'b000, "row100_c700");
    at(10'd10, 10'd101);
    tick;
    tick;
    at(10'd10, 10'd100);
    tick;
    chk("lat_1cyc", {31'd0, green}, 32'd0);
    tick;
    chk("lat_2cyc", {31'd0, green}, 32'd1);
    blank_in = 1'b1;
    pix(10'd10, 10'd100, 3'b000, "blank_force");
    blank_in = 1'b0;
    fill(640, 1'b1, 9'd0, -1, 9'd0);
    pix(10'd5, 10'd100, 3'b010, "old_bank_shown");
    do_swap(1'b1, "swap2_pulse");
    pix(10'd500, 10'd20, 3'b010, "ramp_500_20");
    pix(10'd500, 10'd21, 3'b000, "ramp_500_21");
    pix(10'd3, 10'd3, 3'b010, "ramp_3_3");
    pix(10'd479, 10'd479, 3'b010, "ramp_479_479");
    pix(10'd101, 10'd100, 3'b000, "ramp_101_100");
    fill(639, 1'b0, 9'd200, -1, 9'd0);
    at(10'd0, 10'd480);
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    chk("coinc_noswap", {31'd0, swap_pulse}, 32'd0);
    chk("coinc_full", {31'd0, sample_ready}, 32'd0);
    at(10'd1, 10'd480);
    tick;
    chk("coinc_still", {31'd0, swap_pulse}, 32'd0);
    pix(10'd5, 10'd5, 3'b010, "coinc_oldbank");
    do_swap(1'b1, "coinc_next_vbi");
    pix(10'd5, 10'd200, 3'b010, "row200_c5");
    pix(10'd5, 10'd5, 3'b000, "row200_c5_r5");
    fill(640, 1'b0, 9'd300, 7, 9'd500);
    do_swap(1'b1, "swap4_pulse");
    pix(10'd7, 10'd300, 3'b000, "c7_dark300");
    pix(10'd7, 10'd20, 3'b000, "c7_dark20");
    pix(10'd8, 10'd300, 3'b010, "c8_lit300");
    fill(300, 1'b0, 9'd123, -1, 9'd0);
    chk("midfill_addr", 32'(dut.wr_addr), 32'd300);
    pix(10'd8, 10'd300, 3'b010, "prereset_lit");
    reset = 1'b1;
    tick;
    chk("rst_mid_rgb", {29'd0, red, green, blue}, 32'd0);
    chk("rst_mid_ready", {31'd0, sample_ready}, 32'd1);
    chk("rst_mid_addr", 32'(dut.wr_addr), 32'd0);
    reset = 1'b0;
    pix(10'd8, 10'd300, 3'b000, "postreset_dark");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
